// File: rtl/vram_plane_arbiter.sv
// Banked N-plane VRAM arbiter: one CPU port and one video fetch port share single-ported plane RAMs.
// Define VRAM_PRIO_READ_EN for priority (lowest selected plane) CPU reads instead of OR-combined reads.
module vram_plane_arbiter #(
  parameter int          NPLANES = 6,
  parameter int          ADDR_W  = 13,
  parameter int          DATA_W  = 8,
  parameter logic [7:0]  RD_PORT = 8'hF1,
  parameter logic [7:0]  WR_PORT = 8'hF2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        io_wr,
  input  logic [7:0]                  io_port,
  input  logic [7:0]                  io_din,
  input  logic                        cpu_req,
  input  logic                        cpu_we,
  input  logic [ADDR_W-1:0]           cpu_addr,
  input  logic [DATA_W-1:0]           cpu_din,
  output logic [DATA_W-1:0]           cpu_dout,
  output logic                        cpu_ack,
  input  logic                        vid_req,
  input  logic [ADDR_W-1:0]           vid_addr,
  output logic [NPLANES*DATA_W-1:0]   vid_data,
  output logic                        vid_valid,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [DATA_W-1:0]           ram_din,
  output logic [NPLANES-1:0]          ram_we,
  input  logic [NPLANES*DATA_W-1:0]   ram_q
);

  typedef enum logic [1:0] {IDLE, VID, CPU_RD, CPU_WR} state_t;

  state_t               state;
  logic [NPLANES-1:0]   rd_bank;
  logic [NPLANES-1:0]   wr_bank;
  logic [NPLANES-1:0]   rd_bank_lat;
  logic                 last_vid;

  // Fold the selected plane read data down to one CPU byte.
  function automatic logic [DATA_W-1:0] read_combine(
    input logic [NPLANES-1:0]        sel,
    input logic [NPLANES*DATA_W-1:0] q
  );
    logic [DATA_W-1:0] acc;
    acc = '0;
`ifdef VRAM_PRIO_READ_EN
    for (int i = NPLANES - 1; i >= 0; i--) begin
      if (sel[i]) acc = q[i*DATA_W +: DATA_W];
    end
`else
    for (int i = 0; i < NPLANES; i++) begin
      if (sel[i]) acc = acc | q[i*DATA_W +: DATA_W];
    end
`endif
    return acc;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_bank <= '0;
      wr_bank <= '0;
    end else if (io_wr) begin
      if (io_port == RD_PORT) rd_bank <= io_din[NPLANES-1:0];
      if (io_port == WR_PORT) wr_bank <= io_din[NPLANES-1:0];
    end
  end

  // ram_addr is the plane RAMs' address register: ram_q reflects it one cycle after the grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_vid    <= 1'b0;
      rd_bank_lat <= '0;
      cpu_dout    <= '0;
      cpu_ack     <= 1'b0;
      vid_data    <= '0;
      vid_valid   <= 1'b0;
      ram_addr    <= '0;
      ram_din     <= '0;
      ram_we      <= '0;
    end else begin
      cpu_ack   <= 1'b0;
      vid_valid <= 1'b0;
      ram_we    <= '0;
      case (state)
        IDLE: begin
          // Video wins unless it took the previous slot and the CPU is waiting.
          if (vid_req && !(last_vid && cpu_req)) begin
            ram_addr <= vid_addr;
            last_vid <= 1'b1;
            state    <= VID;
          end else if (cpu_req) begin
            ram_addr <= cpu_addr;
            last_vid <= 1'b0;
            if (cpu_we) begin
              ram_din <= cpu_din;
              ram_we  <= wr_bank;
              state   <= CPU_WR;
            end else begin
              rd_bank_lat <= rd_bank;
              state       <= CPU_RD;
            end
          end
        end
        VID: begin
          vid_data  <= ram_q;
          vid_valid <= 1'b1;
          state     <= IDLE;
        end
        CPU_RD: begin
          cpu_dout <= read_combine(rd_bank_lat, ram_q);
          cpu_ack  <= 1'b1;
          state    <= IDLE;
        end
        CPU_WR: begin
          cpu_ack <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_plane_arbiter.sv
// Directed bench for vram_plane_arbiter with a behavioural plane RAM model.
module tb_vram_plane_arbiter;
  localparam int NP = 6;
  localparam int AW = 13;
  localparam int DW = 8;

`ifdef VRAM_PRIO_READ_EN
  localparam logic [47:0] EXP_RB3 = 48'h0F;
`else
  localparam logic [47:0] EXP_RB3 = 48'hFF;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              io_wr = 1'b0;
  logic [7:0]        io_port = '0;
  logic [7:0]        io_din = '0;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [AW-1:0]     cpu_addr = '0;
  logic [DW-1:0]     cpu_din = '0;
  logic [DW-1:0]     cpu_dout;
  logic              cpu_ack;
  logic              vid_req = 1'b0;
  logic [AW-1:0]     vid_addr = '0;
  logic [NP*DW-1:0]  vid_data;
  logic              vid_valid;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     ram_din;
  logic [NP-1:0]     ram_we;
  logic [NP*DW-1:0]  ram_q;

  int checks = 0;
  int errors = 0;

  vram_plane_arbiter #(.NPLANES(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .io_wr(io_wr), .io_port(io_port), .io_din(io_din),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack), .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_data(vid_data), .vid_valid(vid_valid), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_q(ram_q)
  );

  always #5 clk = ~clk;

  // Plane RAM model: address register lives in the DUT, so read data follows ram_addr.
  logic [DW-1:0] mem [NP][2**AW] = '{default: '0};
  logic          poke_en = 1'b0;
  int            poke_p = 0;
  logic [AW-1:0] poke_a = '0;
  logic [DW-1:0] poke_d = '0;

  always @(posedge clk) begin
    if (poke_en) mem[poke_p][poke_a] <= poke_d;
    for (int i = 0; i < NP; i++) begin
      if (ram_we[i]) mem[i][ram_addr] <= ram_din;
    end
  end

  for (genvar g = 0; g < NP; g++) begin : g_q
    assign ram_q[g*DW +: DW] = mem[g][ram_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic io_write(input logic [7:0] p, input logic [7:0] d);
    io_wr = 1'b1; io_port = p; io_din = d;
    tick;
    io_wr = 1'b0;
  endtask

  task automatic poke(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
    poke_en = 1'b1; poke_p = p; poke_a = a; poke_d = d;
    tick;
    poke_en = 1'b0;
  endtask

  task automatic access(input bit vid, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] din, output logic [47:0] data,
                        output int lat, output int wecnt, output logic [NP-1:0] weval);
    bit done;
    done = 1'b0; lat = 0; wecnt = 0; weval = '0; data = '0;
    if (vid) begin
      vid_req = 1'b1; vid_addr = addr;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = din;
    end
    while (!done && lat < 20) begin
      tick;
      lat++;
      if (ram_we != '0) begin
        wecnt++;
        weval = weval | ram_we;
      end
      if (vid ? vid_valid : cpu_ack) begin
        done = 1'b1;
        data = vid ? vid_data : {40'h0, cpu_dout};
      end
    end
    vid_req = 1'b0;
    cpu_req = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL access_timeout: got no completion within %0d cycles required within 4", lat);
    end
  endtask

  typedef struct {
    bit            vid;
    bit            we;
    logic [7:0]    rdb;
    logic [7:0]    wrb;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [47:0]   exp_d;
    logic [NP-1:0] exp_we;
    int            exp_wecnt;
  } vec_t;

  vec_t vecs [15];

  initial begin
    logic [47:0]   d;
    int            lat, wecnt, vcyc, acyc;
    logic [NP-1:0] wev;
    logic [31:0]   vm, am;

    vecs[0]  = '{0, 1, 8'h00, 8'h05, 13'h0010, 8'hA5, 48'h0, 6'h05, 1};
    vecs[1]  = '{0, 0, 8'h04, 8'h00, 13'h0010, 8'h00, 48'hA5, 6'h00, 0};
    vecs[2]  = '{0, 0, 8'h01, 8'h00, 13'h0010, 8'h00, 48'hA5, 6'h00, 0};
    vecs[3]  = '{0, 0, 8'h02, 8'h00, 13'h0010, 8'h00, 48'h00, 6'h00, 0};
    vecs[4]  = '{0, 0, 8'h03, 8'h00, 13'h0100, 8'h00, EXP_RB3, 6'h00, 0};
    vecs[5]  = '{0, 0, 8'h06, 8'h00, 13'h0100, 8'h00, 48'hF0, 6'h00, 0};
    vecs[6]  = '{1, 0, 8'h00, 8'h00, 13'h1FFF, 8'h00, 48'h665544332211, 6'h00, 0};
    vecs[7]  = '{0, 1, 8'h00, 8'h00, 13'h0100, 8'h55, 48'h0, 6'h00, 0};
    vecs[8]  = '{0, 0, 8'h03, 8'h00, 13'h0100, 8'h00, EXP_RB3, 6'h00, 0};
    vecs[9]  = '{0, 0, 8'h00, 8'h00, 13'h1FFF, 8'h00, 48'h00, 6'h00, 0};
    vecs[10] = '{0, 1, 8'h00, 8'h3F, 13'h0200, 8'h3C, 48'h0, 6'h3F, 1};
    vecs[11] = '{1, 0, 8'h00, 8'h00, 13'h0200, 8'h00, 48'h3C3C3C3C3C3C, 6'h00, 0};
    vecs[12] = '{0, 1, 8'h00, 8'hC2, 13'h0300, 8'h99, 48'h0, 6'h02, 1};
    vecs[13] = '{0, 0, 8'hFE, 8'h00, 13'h0300, 8'h00, 48'h99, 6'h00, 0};
    vecs[14] = '{1, 0, 8'h00, 8'h00, 13'h0010, 8'h00, 48'h0000000000A5_00A5 & 48'hFFFFFFFFFFFF, 6'h00, 0};
    vecs[14].exp_d = 48'h0000_00A5_00A5;

    tick; tick; tick;
    check("reset_cpu_ack", {47'h0, cpu_ack}, 48'h0);
    check("reset_vid_valid", {47'h0, vid_valid}, 48'h0);
    check("reset_ram_we", {42'h0, ram_we}, 48'h0);
    check("reset_ram_addr", {35'h0, ram_addr}, 48'h0);
    check("reset_cpu_dout", {40'h0, cpu_dout}, 48'h0);
    check("reset_vid_data", vid_data, 48'h0);
    reset = 1'b0;
    tick;

    poke(0, 13'h0100, 8'h0F);
    poke(1, 13'h0100, 8'hF0);
    for (int p = 0; p < NP; p++) poke(p, 13'h1FFF, 8'(8'h11 * (p + 1)));

    for (int i = 0; i < 15; i++) begin
      io_write(8'hF1, vecs[i].rdb);
      io_write(8'hF2, vecs[i].wrb);
      access(vecs[i].vid, vecs[i].we, vecs[i].addr, vecs[i].din, d, lat, wecnt, wev);
      check($sformatf("v%0d_latency", i), 48'(lat), 48'd2);
      check($sformatf("v%0d_we_cycles", i), 48'(wecnt), 48'(vecs[i].exp_wecnt));
      check($sformatf("v%0d_we_mask", i), {42'h0, wev}, {42'h0, vecs[i].exp_we});
      if (!vecs[i].we) check($sformatf("v%0d_data", i), d, vecs[i].exp_d);
      tick;
    end

    // Bank change after issue must not affect the in-flight read.
    io_write(8'hF1, 8'h01);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0010;
    tick;
    io_wr = 1'b1; io_port = 8'hF1; io_din = 8'h02;
    tick;
    io_wr = 1'b0; cpu_req = 1'b0;
    check("latch_after_issue_ack", {47'h0, cpu_ack}, 48'h1);
    check("latch_after_issue_dout", {40'h0, cpu_dout}, 48'hA5);
    tick;

    // Bank write in the issue cycle applies only to later accesses.
    cpu_req = 1'b1; cpu_addr = 13'h0010;
    io_wr = 1'b1; io_port = 8'hF1; io_din = 8'h01;
    tick;
    io_wr = 1'b0;
    tick;
    cpu_req = 1'b0;
    check("bank_same_cycle_ack", {47'h0, cpu_ack}, 48'h1);
    check("bank_same_cycle_dout", {40'h0, cpu_dout}, 48'h00);
    tick;

    // Simultaneous requests: video first, CPU right after.
    vid_req = 1'b1; vid_addr = 13'h1FFF;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0010;
    vcyc = -1; acyc = -1;
    for (int t = 1; t <= 12; t++) begin
      tick;
      if (vid_valid && vcyc < 0) begin
        vcyc = t; vid_req = 1'b0;
        check("contend_vid_data", vid_data, 48'h665544332211);
      end
      if (cpu_ack && acyc < 0) begin
        acyc = t; cpu_req = 1'b0;
        check("contend_cpu_dout", {40'h0, cpu_dout}, 48'hA5);
      end
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    check("contend_vid_cycle", 48'(vcyc), 48'd2);
    check("contend_cpu_cycle", 48'(acyc), 48'd4);

    // Both requests held: grants alternate.
    vid_req = 1'b1; cpu_req = 1'b1;
    vm = '0; am = '0;
    for (int t = 1; t <= 16; t++) begin
      tick;
      if (vid_valid) vm[t] = 1'b1;
      if (cpu_ack) am[t] = 1'b1;
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    check("interleave_vid_mask", {16'h0, vm}, 48'h4444);
    check("interleave_cpu_mask", {16'h0, am}, 48'h11110);
    tick; tick;

    // Reset while in CPU_RD aborts the read.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0010;
    tick;
    reset = 1'b1; cpu_req = 1'b0;
    tick;
    check("abort_cpu_ack", {47'h0, cpu_ack}, 48'h0);
    check("abort_ram_we", {42'h0, ram_we}, 48'h0);
    check("abort_ram_addr", {35'h0, ram_addr}, 48'h0);
    check("abort_vid_data", vid_data, 48'h0);
    check("abort_cpu_dout", {40'h0, cpu_dout}, 48'h0);
    reset = 1'b0;
    tick;
    check("abort_no_late_ack", {47'h0, cpu_ack}, 48'h0);
    io_write(8'hF1, 8'h01);
    access(1'b0, 1'b0, 13'h0010, 8'h00, d, lat, wecnt, wev);
    check("post_reset_latency", 48'(lat), 48'd2);
    check("post_reset_dout", d, 48'hA5);
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_plane_arbiter.md
Name: vram_plane_arbiter

Overview:
- N-plane banked VRAM controller: one CPU port, one video fetch port, NPLANES single-ported synchronous plane RAMs with a shared address bus.
- Generalises the fixed 6-plane bank-select scheme. Plane count and widths are parameters; per-plane read/write bank registers are written via I/O ports.
- Replaces dual-port plane RAMs with a time-multiplexed arbiter: video has priority, CPU has a guaranteed fairness slot.
- Sits between CPU bus decode (VRAM window) and the gfx pixel pipeline.

Parameters:
- NPLANES, 6, number of plane RAMs (1..8)
- ADDR_W, 13, plane address width
- DATA_W, 8, plane data width
- RD_PORT, 8'hF1, I/O address of read-bank register
- WR_PORT, 8'hF2, I/O address of write-bank register

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- io_wr  in  1  I/O write strobe (one cycle)
- io_port  in  8  I/O address
- io_din  in  8  I/O write data
- cpu_req  in  1  CPU VRAM request, level, held until cpu_ack
- cpu_we  in  1  1=write, 0=read; stable while cpu_req
- cpu_addr  in  ADDR_W  CPU plane address
- cpu_din  in  DATA_W  CPU write data
- cpu_dout  out  DATA_W  read data, valid with cpu_ack
- cpu_ack  out  1  one-cycle completion pulse
- vid_req  in  1  video fetch request, level, held until vid_valid
- vid_addr  in  ADDR_W  video fetch address
- vid_data  out  NPLANES*DATA_W  all planes; plane i at [i*DATA_W +: DATA_W]
- vid_valid  out  1  one-cycle pulse, vid_data valid
- ram_addr  out  ADDR_W  shared plane address
- ram_din  out  DATA_W  shared plane write data
- ram_we  out  NPLANES  per-plane write enable
- ram_q  in  NPLANES*DATA_W  plane read data, 1-cycle synchronous latency

Behaviour:
- Reset values: rd_bank=0, wr_bank=0, state=IDLE, last_vid=0, cpu_dout=0, cpu_ack=0, vid_data=0, vid_valid=0, ram_addr=0, ram_din=0, ram_we=0.
- Bank registers: io_wr & io_port==RD_PORT -> rd_bank <= io_din[NPLANES-1:0]; same for WR_PORT/wr_bank. Upper io_din bits are ignored. A new value applies to accesses issued from the next cycle on. An access already issued keeps the bank value latched at issue.
- FSM states: IDLE, VID, CPU_RD, CPU_WR.
- IDLE grant rule:
  - if vid_req and not (last_vid and cpu_req): issue video (ram_addr=vid_addr, ram_we=0), last_vid<=1, go VID;
  - else if cpu_req: ram_addr=cpu_addr, last_vid<=0; for a write, ram_din=cpu_din, ram_we=wr_bank, go CPU_WR; for a read, ram_we=0, latch rd_bank, go CPU_RD;
  - else stay in IDLE with ram_we=0.
- VID: vid_data<=ram_q, vid_valid=1 for this cycle; ram_we=0; -> IDLE.
- CPU_RD: cpu_dout <= OR over planes i with latched rd_bank[i] of ram_q plane i; cpu_ack=1; -> IDLE.
- CPU_WR: ram_we=0, cpu_ack=1; -> IDLE.
- Latency:
  - Video: 2 cycles request->valid when uncontended; worst case 4 (one CPU access ahead).
  - CPU: 2 cycles uncontended; worst case 4 (one video access ahead).
  - Neither port can be starved.
- Requesters must drop or change their request on the cycle after ack/valid; a request still high in IDLE is treated as a new access.
- wr_bank=0 write: no plane written, still acked. rd_bank=0 read: cpu_dout=0, acked.
- Multi-bit wr_bank: broadcast write to every selected plane in the same cycle.
- Reset mid-access: abort, state=IDLE, no ack or valid pulse, ram_we=0 the cycle after reset.

Optional Feature:
- Macro VRAM_PRIO_READ_EN.
- Defined: CPU_RD returns only the lowest-index plane selected in latched rd_bank (priority read); other selected planes are ignored.
- Undefined: OR-combine all selected planes, as above.
- Write behaviour and timing are identical in both cases.

Test Plan:
- Reset, then io_wr F2<=0x05, cpu write addr 0x0010 data 0xA5 -> ram_we=6'b000101 for exactly one cycle, cpu_ack 2 cycles after cpu_req; io_wr F1<=0x04 then read 0x0010 -> cpu_dout=0xA5.
- rd_bank=0x03, plane0=0x0F, plane1=0xF0 at addr 0x0100 -> cpu_dout=0xFF; with VRAM_PRIO_READ_EN -> 0x0F.
- vid_req and cpu_req raised same cycle from IDLE -> video granted first (vid_valid cycle 2), cpu_ack cycle 4; vid_req held continuously -> CPU access interleaved after every video access.
- vid_req only, addr 0x1FFF -> vid_data = concatenated plane contents at 0x1FFF, vid_valid exactly one cycle, ram_we never asserted.
- wr_bank=0 write -> cpu_ack pulses, ram_we stays 0, memory unchanged; rd_bank=0 read -> cpu_dout=0.
- reset asserted in CPU_RD -> no cpu_ack, all outputs at reset values next cycle, next request served normally.
